// File: rtl/branch_hazard_ctrl_pkg.sv
// Shared definitions for the ID-stage branch hazard controller:
// FSM state encodings, the register-zero constant, pipeline control
// bundles and the register match helper.
package branch_hazard_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_STALL   = 2'd1,
        ST_RESOLVE = 2'd2
    } state_t;

    localparam logic [4:0] REG_ZERO = 5'd0;

    // Pipeline control bundle driven towards PC, IF/ID and ID/EX.
    typedef struct packed {
        logic pc_write;
        logic ifid_write;
        logic idex_bubble;
        logic ifid_flush;
        logic pc_src;
    } pipe_ctrl_t;

    // Normal flow: PC and IF/ID advance, nothing squashed.
    localparam pipe_ctrl_t CTRL_DEFAULT = '{pc_write: 1'b1, ifid_write: 1'b1,
                                           idex_bubble: 1'b0, ifid_flush: 1'b0,
                                           pc_src: 1'b0};
    // Hold PC and IF/ID, push a nop into ID/EX.
    localparam pipe_ctrl_t CTRL_STALL   = '{pc_write: 1'b0, ifid_write: 1'b0,
                                           idex_bubble: 1'b1, ifid_flush: 1'b0,
                                           pc_src: 1'b0};
    // Taken branch: load the target and discard the fall-through fetch.
    localparam pipe_ctrl_t CTRL_TAKEN   = '{pc_write: 1'b1, ifid_write: 1'b1,
                                           idex_bubble: 1'b0, ifid_flush: 1'b1,
                                           pc_src: 1'b1};

    // A producer destination matches a consumer source unless it is $zero.
    function automatic logic reg_match(input logic [4:0] rd,
                                       input logic [4:0] rs,
                                       input logic [4:0] rt);
        return (rd != REG_ZERO) && ((rd == rs) || (rd == rt));
    endfunction

endpackage

// File: rtl/branch_hazard_ctrl_if.sv
// Signal bundle between the pipeline and the branch hazard controller.
// The pipeline side (master) drives the ID/EX/MEM hazard information and
// the comparator result; the controller side (slave) returns the stall,
// flush and redirect controls plus the stall-cycle counter.
// Handshake: there is no valid/ready pair; every signal is level-sensitive
// and evaluated each cycle, and controller outputs are combinational from
// the current state and the inputs of that same cycle.
interface branch_hazard_ctrl_if #(
    parameter int STALL_CNT_W = 16
);
    logic                   IFID_Branch;
    logic [4:0]             IFID_RegRs;
    logic [4:0]             IFID_RegRt;
    logic                   IDEX_RegWrite;
    logic                   IDEX_MemRead;
    logic [4:0]             IDEX_RegRd;
    logic                   EXMEM_MemRead;
    logic [4:0]             EXMEM_RegRd;
    logic                   BranchTaken;
    logic                   PCWrite;
    logic                   IFIDWrite;
    logic                   IDEX_Bubble;
    logic                   IFID_Flush;
    logic                   PCSrc;
    logic [STALL_CNT_W-1:0] StallCount;

    modport master (
        output IFID_Branch, IFID_RegRs, IFID_RegRt,
        output IDEX_RegWrite, IDEX_MemRead, IDEX_RegRd,
        output EXMEM_MemRead, EXMEM_RegRd, BranchTaken,
        input  PCWrite, IFIDWrite, IDEX_Bubble, IFID_Flush, PCSrc, StallCount
    );

    modport slave (
        input  IFID_Branch, IFID_RegRs, IFID_RegRt,
        input  IDEX_RegWrite, IDEX_MemRead, IDEX_RegRd,
        input  EXMEM_MemRead, EXMEM_RegRd, BranchTaken,
        output PCWrite, IFIDWrite, IDEX_Bubble, IFID_Flush, PCSrc, StallCount
    );
endinterface

// File: rtl/branch_dep_detect.sv
// Combinational operand dependency detector for a consumer in ID.
// need2: load in EX (two cycles until its data is forwardable to ID).
// need1: ALU result in EX or load in MEM (one cycle until forwardable).
// Kept free of branch qualification so the load-use unit can reuse it.
module branch_dep_detect
    import branch_hazard_ctrl_pkg::*;
(
    input  logic [4:0] i_rs,
    input  logic [4:0] i_rt,
    input  logic       i_idex_regwrite,
    input  logic       i_idex_memread,
    input  logic [4:0] i_idex_rd,
    input  logic       i_exmem_memread,
    input  logic [4:0] i_exmem_rd,
    output logic       o_need1,
    output logic       o_need2
);
    logic w_idex_match;
    logic w_exmem_match;

    // Match each in-flight destination against the ID sources, then qualify by producer kind.
    always_comb begin
        w_idex_match  = reg_match(i_idex_rd, i_rs, i_rt);
        w_exmem_match = reg_match(i_exmem_rd, i_rs, i_rt);
        o_need2       = i_idex_memread & w_idex_match;
        o_need1       = (i_idex_regwrite & ~i_idex_memread & w_idex_match)
                      | (i_exmem_memread & w_exmem_match);
    end
endmodule

// File: rtl/branch_hazard_ctrl.sv
// Early branch resolution sequencer. Stalls a branch in ID until its
// operands can be bypassed to the ID comparator, then redirects and
// flushes when the branch is taken. Also counts stall cycles (saturating).
module branch_hazard_ctrl
    import branch_hazard_ctrl_pkg::*;
#(
    parameter int STALL_CNT_W = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    branch_hazard_ctrl_if.slave  bus,
    output state_t               o_dbg_state
);
    state_t                 r_state;
    state_t                 w_next_state;
    pipe_ctrl_t             w_ctrl;
    logic                   w_stall;
    logic                   w_need1;
    logic                   w_need2;
    logic [STALL_CNT_W-1:0] r_stall_cnt;

    branch_dep_detect u_dep (
        .i_rs            (bus.IFID_RegRs),
        .i_rt            (bus.IFID_RegRt),
        .i_idex_regwrite (bus.IDEX_RegWrite),
        .i_idex_memread  (bus.IDEX_MemRead),
        .i_idex_rd       (bus.IDEX_RegRd),
        .i_exmem_memread (bus.EXMEM_MemRead),
        .i_exmem_rd      (bus.EXMEM_RegRd),
        .o_need1         (w_need1),
        .o_need2         (w_need2)
    );

    // State register; reset abandons any stall sequence in progress.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next state and Mealy output decode; reset forces default controls.
    always_comb begin
        w_next_state = r_state;
        w_ctrl       = CTRL_DEFAULT;
        w_stall      = 1'b0;
        if (!rst_n) begin
            w_next_state = ST_IDLE;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (bus.IFID_Branch) begin
                        if (w_need2) begin
                            w_stall      = 1'b1;
                            w_next_state = ST_STALL;
                        end else if (w_need1) begin
                            w_stall      = 1'b1;
                            w_next_state = ST_RESOLVE;
                        end else if (bus.BranchTaken) begin
                            w_ctrl = CTRL_TAKEN;
                        end
                    end
                end
                ST_STALL: begin
                    if (!bus.IFID_Branch) begin
                        w_next_state = ST_IDLE;
                    end else begin
                        w_stall      = 1'b1;
                        w_next_state = ST_RESOLVE;
                    end
                end
                ST_RESOLVE: begin
                    // Operands are forwardable by now, so no hazard re-check.
                    w_next_state = ST_IDLE;
                    if (bus.IFID_Branch && bus.BranchTaken) begin
                        w_ctrl = CTRL_TAKEN;
                    end
                end
                default: begin
                    w_next_state = ST_IDLE;
                end
            endcase
            if (w_stall) begin
                w_ctrl = CTRL_STALL;
            end
        end
    end

    // Saturating count of cycles in which the stall controls were asserted.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_stall_cnt <= '0;
        end else if (w_stall && (r_stall_cnt != '1)) begin
            r_stall_cnt <= r_stall_cnt + 1'b1;
        end
    end

    assign bus.PCWrite     = w_ctrl.pc_write;
    assign bus.IFIDWrite   = w_ctrl.ifid_write;
    assign bus.IDEX_Bubble = w_ctrl.idex_bubble;
    assign bus.IFID_Flush  = w_ctrl.ifid_flush;
    assign bus.PCSrc       = w_ctrl.pc_src;
    assign bus.StallCount  = r_stall_cnt;
    assign o_dbg_state     = r_state;
endmodule

// File: tb/tb_branch_hazard_ctrl.sv
// Directed bench for branch_hazard_ctrl with a 4-bit stall counter.
// The driver applies one input vector per cycle just after the rising edge
// and queues the hand-computed expected controls/counter/state; the monitor
// pops and compares on the falling edge.
module tb_branch_hazard_ctrl;
    import branch_hazard_ctrl_pkg::*;

    localparam int W = 4;
    // Expected control order: {PCWrite, IFIDWrite, IDEX_Bubble, IFID_Flush, PCSrc}
    localparam logic [4:0] D = 5'b11000;
    localparam logic [4:0] S = 5'b00100;
    localparam logic [4:0] T = 5'b11011;
    localparam logic [1:0] IDL = 2'd0;
    localparam logic [1:0] STL = 2'd1;
    localparam logic [1:0] RES = 2'd2;

    logic   clk;
    logic   rst_n;
    state_t dbg_state;

    branch_hazard_ctrl_if #(.STALL_CNT_W(W)) bus ();

    branch_hazard_ctrl #(.STALL_CNT_W(W)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .bus         (bus),
        .o_dbg_state (dbg_state)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // scoreboard
    logic [10:0] exp_q[$];
    string       name_q[$];
    int          checks = 0;
    int          errors = 0;
    logic        mon_en = 1'b0;

    always @(negedge clk) begin
        if (mon_en) begin
            logic [10:0] act;
            logic [10:0] ex;
            string       nm;
            act = {bus.PCWrite, bus.IFIDWrite, bus.IDEX_Bubble, bus.IFID_Flush,
                   bus.PCSrc, bus.StallCount, dbg_state};
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL underflow: got %b, required an expectation", act);
            end else begin
                ex = exp_q.pop_front();
                nm = name_q.pop_front();
                if (act !== ex) begin
                    errors++;
                    $display("FAIL %s: got ctrl=%b cnt=%0d st=%0d, required ctrl=%b cnt=%0d st=%0d",
                             nm, act[10:6], act[5:2], act[1:0], ex[10:6], ex[5:2], ex[1:0]);
                end
            end
        end
    end

    // driver: one cycle of inputs plus its expected response
    task automatic cyc(input logic rst, input logic br,
                       input logic [4:0] rs, input logic [4:0] rt,
                       input logic idrw, input logic idmr, input logic [4:0] idrd,
                       input logic exmr, input logic [4:0] exrd, input logic tk,
                       input logic [4:0] e_ctrl, input logic [3:0] e_cnt,
                       input logic [1:0] e_st, input string nm);
        @(posedge clk);
        #1;
        rst_n             = ~rst;
        bus.IFID_Branch   = br;
        bus.IFID_RegRs    = rs;
        bus.IFID_RegRt    = rt;
        bus.IDEX_RegWrite = idrw;
        bus.IDEX_MemRead  = idmr;
        bus.IDEX_RegRd    = idrd;
        bus.EXMEM_MemRead = exmr;
        bus.EXMEM_RegRd   = exrd;
        bus.BranchTaken   = tk;
        exp_q.push_back({e_ctrl, e_cnt, e_st});
        name_q.push_back(nm);
        mon_en = 1'b1;
    endtask

    initial begin
        int c;
        rst_n             = 1'b0;
        bus.IFID_Branch   = 1'b1;
        bus.IFID_RegRs    = 5'd1;
        bus.IFID_RegRt    = 5'd2;
        bus.IDEX_RegWrite = 1'b1;
        bus.IDEX_MemRead  = 1'b1;
        bus.IDEX_RegRd    = 5'd1;
        bus.EXMEM_MemRead = 1'b0;
        bus.EXMEM_RegRd   = 5'd0;
        bus.BranchTaken   = 1'b1;

        // reset held with a need2 branch present
        cyc(1, 1, 1, 2, 1, 1, 1, 0, 0, 1, D, 0, IDL, "rst_hold0");
        cyc(1, 1, 1, 2, 1, 1, 1, 0, 0, 1, D, 0, IDL, "rst_hold1");
        cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, D, 0, IDL, "post_rst_idle");

        // lw $1 in EX, beq $1,$2 taken: stall, stall, redirect
        cyc(0, 1, 1, 2, 1, 1, 1, 0, 0, 1, S, 0, IDL, "lw_stall_t");
        cyc(0, 1, 1, 2, 0, 0, 0, 1, 1, 1, S, 1, STL, "lw_stall_t1");
        cyc(0, 1, 1, 2, 0, 0, 0, 0, 0, 1, T, 2, RES, "lw_resolve_taken");
        cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, D, 2, IDL, "lw_after");

        // add $3 in EX, bne $4,$3 not taken: one stall, no flush
        cyc(0, 1, 4, 3, 1, 0, 3, 0, 0, 1, S, 2, IDL, "alu_stall");
        cyc(0, 1, 4, 3, 0, 0, 0, 0, 3, 0, D, 3, RES, "alu_resolve_nt");
        cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, D, 3, IDL, "alu_after");

        // writes to $zero never stall
        cyc(0, 1, 0, 5, 1, 0, 0, 0, 0, 1, T, 3, IDL, "rd0_taken");
        cyc(0, 1, 0, 5, 1, 0, 0, 1, 0, 0, D, 3, IDL, "rd0_nt");

        // load in MEM on Rt: one stall, then taken
        cyc(0, 1, 7, 8, 0, 0, 0, 1, 8, 0, S, 3, IDL, "lwmem_stall");
        cyc(0, 1, 7, 8, 0, 0, 0, 0, 0, 1, T, 4, RES, "lwmem_resolve");

        // need1 and need2 together: two stalls
        cyc(0, 1, 9, 10, 1, 1, 9, 1, 10, 1, S, 4, IDL, "both_stall_t");
        cyc(0, 1, 9, 10, 0, 0, 0, 1, 9, 1, S, 5, STL, "both_stall_t1");
        cyc(0, 1, 9, 10, 0, 0, 0, 0, 0, 0, D, 6, RES, "both_resolve_nt");
        cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, D, 6, IDL, "both_after");

        // branch vanishes in STALL: abort with defaults
        cyc(0, 1, 1, 2, 1, 1, 2, 0, 0, 0, S, 6, IDL, "abort_stl_enter");
        cyc(0, 0, 1, 2, 0, 0, 0, 1, 2, 1, D, 7, STL, "abort_stl");
        cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, D, 7, IDL, "abort_stl_idle");

        // branch vanishes in RESOLVE: taken is ignored
        cyc(0, 1, 6, 2, 1, 0, 6, 0, 0, 0, S, 7, IDL, "abort_res_enter");
        cyc(0, 0, 6, 2, 0, 0, 0, 0, 6, 1, D, 8, RES, "abort_res");
        cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, D, 8, IDL, "abort_res_idle");

        // reset pulse while in STALL
        cyc(0, 1, 1, 2, 1, 1, 1, 0, 0, 0, S, 8, IDL, "pulse_enter");
        cyc(1, 1, 1, 2, 0, 0, 0, 1, 1, 1, D, 0, IDL, "pulse_in_stall");
        cyc(0, 1, 1, 2, 0, 0, 0, 0, 0, 0, D, 0, IDL, "pulse_release");

        // saturation: 9 load sequences give 18 stall cycles, counter stops at 15
        c = 0;
        for (int i = 0; i < 9; i++) begin
            cyc(0, 1, 11, 12, 1, 1, 12, 0, 0, 1, S, c[3:0], IDL, "sat_stall_a");
            c = (c < 15) ? c + 1 : 15;
            cyc(0, 1, 11, 12, 0, 0, 0, 1, 12, 1, S, c[3:0], STL, "sat_stall_b");
            c = (c < 15) ? c + 1 : 15;
            cyc(0, 1, 11, 12, 0, 0, 0, 0, 0, 0, D, c[3:0], RES, "sat_resolve");
        end
        cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, D, 15, IDL, "sat_hold");

        @(posedge clk);
        #1;
        mon_en = 1'b0;
        repeat (2) @(posedge clk);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d pending, required 0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
